// File: rtl/mmu_ptw.sv
// ============================================================================
// mmu_ptw : Sv39 page-table walker, two requesters, one outstanding PTE read
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mmu_ptw (
  input  logic         clk,
  input  logic         rst,
  input  logic [43:0]  satp_ppn,
  input  logic [1:0]   req_valid,
  input  logic [127:0] req_va,
  output logic [1:0]   req_ready,
  input  logic         flush,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [63:0]  mem_addr,
  input  logic         mem_rvalid,
  input  logic [63:0]  mem_rdata,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [63:0]  resp_pte,
  output logic [1:0]   resp_level,
  output logic         resp_fault
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_WAIT = 3'd2,
    RESP     = 3'd3,
    DRAIN    = 3'd4
  } state_e;

  state_e      state_q;
  logic        prio_q;
  logic        id_q;
  logic [26:0] vpn_q;
  logic [1:0]  level_q;
  logic        mem_req_valid_q;
  logic [63:0] mem_addr_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [63:0] resp_pte_q;
  logic [1:0]  resp_level_q;
  logic        resp_fault_q;

  function automatic logic [8:0] vpn_sel(input logic [26:0] vpn, input logic [1:0] lvl);
    case (lvl)
      2'd2:    return vpn[26:18];
      2'd1:    return vpn[17:9];
      default: return vpn[8:0];
    endcase
  endfunction

  function automatic logic [63:0] pte_addr(input logic [43:0] ppn, input logic [8:0] vpn);
    return {8'b0, ppn, 12'b0} + {52'b0, vpn, 3'b0};
  endfunction

  // Tie goes to prio_q, which always names the loser of the previous grant.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && !flush) begin
      if (&req_valid) req_ready = prio_q ? 2'b10 : 2'b01;
      else            req_ready = req_valid;
    end
  end

  logic        gnt;
  logic        gnt_id;
  logic [63:0] gnt_va;
  logic        canon_ok;
  assign gnt      = |req_ready;
  assign gnt_id   = req_ready[1];
  assign gnt_va   = gnt_id ? req_va[127:64] : req_va[63:0];
  assign canon_ok = (&gnt_va[63:38]) | ~(|gnt_va[63:38]);

  logic       pte_v, pte_r, pte_w, pte_x;
  logic       pte_leaf, pte_bad, pte_misal, pte_fault;
  logic [1:0] level_d;
  assign pte_v     = mem_rdata[0];
  assign pte_r     = mem_rdata[1];
  assign pte_w     = mem_rdata[2];
  assign pte_x     = mem_rdata[3];
  assign pte_leaf  = pte_r | pte_x;
  assign pte_bad   = !pte_v || (!pte_r && pte_w);
  assign pte_misal = (level_q == 2'd2 && |mem_rdata[27:10]) ||
                     (level_q == 2'd1 && |mem_rdata[18:10]);
  assign pte_fault = pte_bad || (pte_leaf && pte_misal) || (!pte_leaf && level_q == 2'd0);
  assign level_d   = level_q - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      id_q            <= 1'b0;
      vpn_q           <= '0;
      level_q         <= 2'd0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_pte_q      <= '0;
      resp_level_q    <= 2'd0;
      resp_fault_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt) begin
            id_q    <= gnt_id;
            vpn_q   <= gnt_va[38:12];
            level_q <= 2'd2;
            prio_q  <= ~gnt_id;
            if (!canon_ok) begin
              resp_valid_q <= 1'b1;
              resp_id_q    <= gnt_id;
              resp_pte_q   <= '0;
              resp_level_q <= 2'd2;
              resp_fault_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              mem_addr_q      <= pte_addr(satp_ppn, gnt_va[38:30]);
              mem_req_valid_q <= 1'b1;
              state_q         <= MEM_REQ;
            end
          end
        end
        MEM_REQ: begin
          // A read already handed to memory must be drained before reuse.
          if (flush) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= mem_req_ready ? DRAIN : IDLE;
          end else if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              state_q <= IDLE;
            end else if (pte_fault || pte_leaf) begin
              resp_valid_q <= 1'b1;
              resp_id_q    <= id_q;
              resp_pte_q   <= pte_fault ? 64'd0 : mem_rdata;
              resp_level_q <= level_q;
              resp_fault_q <= pte_fault;
              state_q      <= RESP;
            end else begin
              level_q         <= level_d;
              mem_addr_q      <= pte_addr(mem_rdata[53:10], vpn_sel(vpn_q, level_d));
              mem_req_valid_q <= 1'b1;
              state_q         <= MEM_REQ;
            end
          end else if (flush) begin
            state_q <= DRAIN;
          end
        end
        RESP:    state_q <= IDLE;
        DRAIN:   if (mem_rvalid) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_pte      = resp_pte_q;
  assign resp_level    = resp_level_q;
  assign resp_fault    = resp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mmu_ptw.sv
// ============================================================================
// tb_mmu_ptw : table-driven walks with a response scoreboard and a PTE memory
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmu_ptw;

  logic         clk = 1'b0;
  logic         rst;
  logic [43:0]  satp_ppn;
  logic [1:0]   req_valid;
  logic [127:0] req_va;
  logic [1:0]   req_ready;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_addr;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;
  logic         resp_valid;
  logic         resp_id;
  logic [63:0]  resp_pte;
  logic [1:0]   resp_level;
  logic         resp_fault;

  always #5 clk = ~clk;

  mmu_ptw dut (
    .clk(clk), .rst(rst), .satp_ppn(satp_ppn),
    .req_valid(req_valid), .req_va(req_va), .req_ready(req_ready), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_pte(resp_pte),
    .resp_level(resp_level), .resp_fault(resp_fault)
  );

  typedef struct packed {
    logic [43:0]       satp;
    logic [63:0]       va;
    logic [1:0]        nrd;
    logic [2:0][63:0]  pte;
    logic [2:0][63:0]  addr;
    logic              fault;
    logic [1:0]        lvl;
    logic [63:0]       rpte;
  } vec_t;

  typedef struct packed {
    logic        id;
    logic        fault;
    logic [1:0]  lvl;
    logic [63:0] rpte;
    int          gcyc;
    int          lat;
  } exp_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  exp_t        sb [$];
  logic [63:0] q_addr [$];
  logic [63:0] q_pte [$];
  int n_cmp = 0, n_err = 0, cyc = 0, rdelay = 0, mreq_seen = 0;
  bit rv_own = 0, rv_pend = 0;
  int rv_cnt = 0;
  logic [63:0] rv_data;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mkv(input logic [43:0] satp, input logic [63:0] va, input logic [1:0] nrd,
                               input logic [63:0] p0, p1, p2, a0, a1, a2,
                               input logic fault, input logic [1:0] lvl, input logic [63:0] rpte);
    vec_t v;
    v.satp = satp; v.va = va; v.nrd = nrd;
    v.pte = {p2, p1, p0}; v.addr = {a2, a1, a0};
    v.fault = fault; v.lvl = lvl; v.rpte = rpte;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic arm(input int id, input vec_t v, input bit want_resp);
    exp_t e;
    for (int i = 0; i < int'(v.nrd); i++) begin
      q_addr.push_back(v.addr[i]);
      q_pte.push_back(v.pte[i]);
    end
    if (want_resp) begin
      e.id = id[0]; e.fault = v.fault; e.lvl = v.lvl; e.rpte = v.rpte;
      e.gcyc = cyc; e.lat = (v.nrd == 0) ? 1 : 2 * int'(v.nrd) + 1;
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge following the grant.
  task automatic start_walk(input int id, input vec_t v, input bit want_resp);
    bit got = 0;
    satp_ppn = v.satp;
    if (id == 1) req_va[127:64] = v.va; else req_va[63:0] = v.va;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (req_ready[id]) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) arm(id, v, want_resp); else fail_now("grant_timeout");
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      fail_now("resp_timeout");
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, ".req_ready"}, {62'd0, req_ready}, 64'd0);
    chk({p, ".mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
    chk({p, ".mem_addr"}, mem_addr, 64'd0);
    chk({p, ".resp_valid"}, {63'd0, resp_valid}, 64'd0);
    chk({p, ".resp_id"}, {63'd0, resp_id}, 64'd0);
    chk({p, ".resp_pte"}, resp_pte, 64'd0);
    chk({p, ".resp_level"}, {62'd0, resp_level}, 64'd0);
    chk({p, ".resp_fault"}, {63'd0, resp_fault}, 64'd0);
  endtask

  // Response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (resp_valid) begin
        if (sb.size() == 0) fail_now("unexpected_resp");
        else begin
          e = sb.pop_front();
          chk("resp_id", {63'd0, resp_id}, {63'd0, e.id});
          chk("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
          chk("resp_level", {62'd0, resp_level}, {62'd0, e.lvl});
          chk("resp_pte", resp_pte, e.rpte);
          chk("resp_latency", 64'(cyc - e.gcyc), 64'(e.lat));
        end
      end
    end
  end

  // PTE memory: checks each accepted address and answers rdelay cycles later
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rv_own) begin mem_rvalid = 1'b0; rv_own = 0; end
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1; mem_rdata = rv_data; rv_own = 1; rv_pend = 0;
        end else rv_cnt--;
      end
      if (mem_req_valid) mreq_seen++;
      if (mem_req_valid && mem_req_ready && !rst) begin
        if (q_addr.size() == 0) fail_now("unexpected_mem_req");
        else begin
          chk("mem_addr", mem_addr, q_addr.pop_front());
          rv_data = q_pte.pop_front();
          rv_pend = 1; rv_cnt = rdelay;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0;
    rst = 1'b1; satp_ppn = '0; req_valid = '0; req_va = '0; flush = 1'b0;
    mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

    vecs[0]  = mkv(44'h80000, 64'h1000, 2'd3, 64'h20000401, 64'h20000801, 64'h200000CF,
                   64'h80000000, 64'h80001000, 64'h80002008, 1'b0, 2'd0, 64'h200000CF);
    vecs[1]  = mkv(44'h80000, 64'h40000000, 2'd1, 64'h200000CF, 0, 0,
                   64'h80000008, 0, 0, 1'b0, 2'd2, 64'h200000CF);
    vecs[2]  = mkv(44'h80000, 64'h1000, 2'd1, 64'h200004CF, 0, 0,
                   64'h80000000, 0, 0, 1'b1, 2'd2, 64'h0);
    vecs[3]  = mkv(44'h80000, 64'h200000, 2'd2, 64'h20000401, 64'h200800CF, 0,
                   64'h80000000, 64'h80001008, 0, 1'b0, 2'd1, 64'h200800CF);
    vecs[4]  = mkv(44'h80000, 64'h200000, 2'd2, 64'h20000401, 64'h200804CF, 0,
                   64'h80000000, 64'h80001008, 0, 1'b1, 2'd1, 64'h0);
    vecs[5]  = mkv(44'h80000, 64'h1000, 2'd1, 64'h4, 0, 0,
                   64'h80000000, 0, 0, 1'b1, 2'd2, 64'h0);
    vecs[6]  = mkv(44'h80000, 64'h1000, 2'd1, 64'h5, 0, 0,
                   64'h80000000, 0, 0, 1'b1, 2'd2, 64'h0);
    vecs[7]  = mkv(44'h80000, 64'h1000, 2'd3, 64'h20000401, 64'h20000801, 64'h20000C01,
                   64'h80000000, 64'h80001000, 64'h80002008, 1'b1, 2'd0, 64'h0);
    vecs[8]  = mkv(44'h80000, 64'h0000_8000_0000_0000, 2'd0, 0, 0, 0,
                   0, 0, 0, 1'b1, 2'd2, 64'h0);
    vecs[9]  = mkv(44'h80000, 64'hFFFF_FFC0_0000_0000, 2'd1, 64'h200000CF, 0, 0,
                   64'h80000800, 0, 0, 1'b0, 2'd2, 64'h200000CF);
    vecs[10] = mkv(44'h12345, 64'h403000, 2'd3, 64'h2AF001, 64'hFFC0_0000_0000_0401, 64'h9,
                   64'h12345000, 64'hABC010, 64'h1018, 1'b0, 2'd0, 64'h9);

    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table: walks alternate requesters; results must hold after resp_valid
    for (int i = 0; i < NV; i++) begin
      m0 = mreq_seen;
      start_walk(i % 2, vecs[i], 1'b1);
      wait_done();
      if (vecs[i].nrd == 0) chk("canon_no_memreq", 64'(mreq_seen - m0), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("hold_valid", {63'd0, resp_valid}, 64'd0);
      chk("hold_pte", resp_pte, vecs[i].rpte);
      chk("hold_fault", {63'd0, resp_fault}, {63'd0, vecs[i].fault});
      @(negedge clk);
    end

    // Stray read data while idle is ignored
    mem_rvalid = 1'b1; mem_rdata = 64'h200000CF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("stray_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);

    // Flush in IDLE blocks the grant for that cycle only
    satp_ppn = vecs[1].satp; req_va[63:0] = vecs[1].va; req_valid = 2'b01; flush = 1'b1;
    #1 chk("flush_idle_block", {62'd0, req_ready}, 64'd0);
    flush = 1'b0;
    #1 chk("flush_idle_release", {62'd0, req_ready}, 64'd1);
    arm(0, vecs[1], 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done();
    @(negedge clk);

    // Flush in MEM_WAIT with a slow read: drain, then IDLE the cycle after rvalid
    rdelay = 5;
    start_walk(0, vecs[1], 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req_va[127:64] = vecs[9].va; req_valid = 2'b10;
    begin
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
        #3;
        chk("drain_no_grant", {62'd0, req_ready}, 64'd0);
        if (mem_rvalid) begin seen = 1; break; end
        @(negedge clk);
      end
      if (!seen) fail_now("drain_rvalid_timeout");
    end
    @(negedge clk); #1;
    chk("drain_then_idle", {62'd0, req_ready}, 64'd2);
    rdelay = 0;
    arm(1, vecs[9], 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done();
    @(negedge clk);

    // Flush in MEM_REQ before the handshake drops the request
    mem_req_ready = 1'b0;
    start_walk(0, vecs[1], 1'b0);
    #1 chk("memreq_valid_before_flush", {63'd0, mem_req_valid}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("memreq_dropped", {63'd0, mem_req_valid}, 64'd0);
    q_addr.delete(); q_pte.delete();
    mem_req_ready = 1'b1;
    req_va[63:0] = vecs[5].va; req_valid = 2'b01;
    #1 chk("memreq_flush_idle", {62'd0, req_ready}, 64'd1);
    arm(0, vecs[5], 1'b1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_done();
    @(negedge clk);

    // Backpressure: request and address stay stable, then reset mid-wait
    mem_req_ready = 1'b0;
    start_walk(0, vecs[0], 1'b0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("bp_addr", mem_addr, vecs[0].addr[0]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1 chk_zero("midrst");
    rst = 1'b0;
    q_addr.delete(); q_pte.delete();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h200000CF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("late_rvalid_no_resp", {63'd0, resp_valid}, 64'd0);
    @(negedge clk);

    // Round-robin with both requesters held high
    satp_ppn = 44'h80000;
    req_va = {vecs[9].va, vecs[1].va};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      bit got = 0;
      for (int k = 0; k < 50; k++) begin
        #1;
        if (req_ready != 2'b00) begin got = 1; break; end
        @(negedge clk);
      end
      if (!got) begin fail_now("arb_timeout"); break; end
      chk("arb_grant", {62'd0, req_ready}, (g % 2 == 0) ? 64'd1 : 64'd2);
      if (req_ready[1]) arm(1, vecs[9], 1'b1); else arm(0, vecs[1], 1'b1);
      @(negedge clk);
    end
    req_valid = 2'b00;
    wait_done();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
